// File: rtl/score_keeper.sv
// Score, lives and high-score bookkeeping for the Fruit Ninja game.
// Scores are held directly as three BCD digits so the seven-segment
// decoders downstream can be fed without any binary-to-BCD conversion.
module score_keeper #(
    parameter int LIVES_INIT = 3
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       start,
    input  logic       hit,
    input  logic       miss,
    input  logic       bomb,
    output logic [3:0] score_d0,
    output logic [3:0] score_d1,
    output logic [3:0] score_d2,
    output logic [3:0] hi_d0,
    output logic [3:0] hi_d1,
    output logic [3:0] hi_d2,
    output logic [3:0] lives,
    output logic       playing,
    output logic       game_over
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_PLAY = 2'd1;
    localparam logic [1:0] ST_OVER = 2'd2;

    localparam logic [3:0] LIVES_RST = 4'(LIVES_INIT);

    logic [1:0] state_q, state_d;
    logic [3:0] score0_q, score0_d;
    logic [3:0] score1_q, score1_d;
    logic [3:0] score2_q, score2_d;
    logic [3:0] hi0_q, hi0_d;
    logic [3:0] hi1_q, hi1_d;
    logic [3:0] hi2_q, hi2_d;
    logic [3:0] lives_q, lives_d;
    logic       playing_q, playing_d;
    logic       over_q, over_d;

    logic [3:0] inc0, inc1, inc2;

    // BCD increment of the current score, holding at 999 instead of wrapping
    always_comb begin
        inc0 = score0_q;
        inc1 = score1_q;
        inc2 = score2_q;
        if (!(score2_q == 4'd9 && score1_q == 4'd9 && score0_q == 4'd9)) begin
            if (score0_q != 4'd9) begin
                inc0 = score0_q + 4'd1;
            end else begin
                inc0 = 4'd0;
                if (score1_q != 4'd9) begin
                    inc1 = score1_q + 4'd1;
                end else begin
                    inc1 = 4'd0;
                    inc2 = score2_q + 4'd1;
                end
            end
        end
    end

    // Game sequencing: apply this cycle's events, end the game when lives run out
    always_comb begin
        state_d  = state_q;
        score0_d = score0_q;
        score1_d = score1_q;
        score2_d = score2_q;
        hi0_d    = hi0_q;
        hi1_d    = hi1_q;
        hi2_d    = hi2_q;
        lives_d  = lives_q;
        case (state_q)
            ST_IDLE, ST_OVER: begin
                if (start) begin
                    state_d  = ST_PLAY;
                    score0_d = 4'd0;
                    score1_d = 4'd0;
                    score2_d = 4'd0;
                    lives_d  = LIVES_RST;
                end
            end
            ST_PLAY: begin
                if (bomb) begin
                    lives_d = 4'd0;
                end else begin
                    if (hit) begin
                        score0_d = inc0;
                        score1_d = inc1;
                        score2_d = inc2;
                    end
                    if (miss && lives_q != 4'd0) begin
                        lives_d = lives_q - 4'd1;
                    end
                end
                if (lives_d == 4'd0) begin
                    state_d = ST_OVER;
                    if ({score2_d, score1_d, score0_d} > {hi2_q, hi1_q, hi0_q}) begin
                        hi0_d = score0_d;
                        hi1_d = score1_d;
                        hi2_d = score2_d;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        playing_d = (state_d == ST_PLAY);
        over_d    = (state_d == ST_OVER);
    end

    // State and output registers, all cleared asynchronously
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q   <= ST_IDLE;
            score0_q  <= 4'd0;
            score1_q  <= 4'd0;
            score2_q  <= 4'd0;
            hi0_q     <= 4'd0;
            hi1_q     <= 4'd0;
            hi2_q     <= 4'd0;
            lives_q   <= LIVES_RST;
            playing_q <= 1'b0;
            over_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            score0_q  <= score0_d;
            score1_q  <= score1_d;
            score2_q  <= score2_d;
            hi0_q     <= hi0_d;
            hi1_q     <= hi1_d;
            hi2_q     <= hi2_d;
            lives_q   <= lives_d;
            playing_q <= playing_d;
            over_q    <= over_d;
        end
    end

    assign score_d0  = score0_q;
    assign score_d1  = score1_q;
    assign score_d2  = score2_q;
    assign hi_d0     = hi0_q;
    assign hi_d1     = hi1_q;
    assign hi_d2     = hi2_q;
    assign lives     = lives_q;
    assign playing   = playing_q;
    assign game_over = over_q;

endmodule

// File: tb/tb_score_keeper.sv
// Bench for score_keeper: a behavioural game model predicts each cycle's
// outputs, pushes them to a queue, and they are popped and compared
// against the DUT just after the clock edge.
module tb_score_keeper;

    localparam int LIVES_INIT = 3;

    typedef struct packed {
        logic [11:0] score;
        logic [11:0] hi;
        logic [3:0]  lives;
        logic        playing;
        logic        over;
    } expT;

    logic       clock = 1'b0;
    logic       resetn = 1'b0;
    logic       start = 1'b0;
    logic       hit = 1'b0;
    logic       miss = 1'b0;
    logic       bomb = 1'b0;
    logic [3:0] score_d0, score_d1, score_d2;
    logic [3:0] hi_d0, hi_d1, hi_d2;
    logic [3:0] lives;
    logic       playing, game_over;

    int  checkCount = 0;
    int  errorCount = 0;
    expT expQ[$];

    // Model state: 0 idle, 1 play, 2 over; scores held as plain integers
    int mState = 0;
    int mScore = 0;
    int mHi = 0;
    int mLives = LIVES_INIT;

    score_keeper #(.LIVES_INIT(LIVES_INIT)) dut (
        .clock(clock), .resetn(resetn), .start(start), .hit(hit), .miss(miss), .bomb(bomb),
        .score_d0(score_d0), .score_d1(score_d1), .score_d2(score_d2),
        .hi_d0(hi_d0), .hi_d1(hi_d1), .hi_d2(hi_d2),
        .lives(lives), .playing(playing), .game_over(game_over)
    );

    always #5 clock = ~clock;

    // Hard stop so a stuck run still reports
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [11:0] toBcd(input int n);
        return {4'(n / 100), 4'((n / 10) % 10), 4'(n % 10)};
    endfunction

    task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic pushExpected();
        expT e;
        e.score   = toBcd(mScore);
        e.hi      = toBcd(mHi);
        e.lives   = 4'(mLives);
        e.playing = (mState == 1);
        e.over    = (mState == 2);
        expQ.push_back(e);
    endtask

    task automatic popAndCompare();
        expT e;
        if (expQ.size() == 0) begin
            checkOutput("queueEmpty", 16'd1, 16'd0);
            return;
        end
        e = expQ.pop_front();
        checkOutput("score", {4'd0, score_d2, score_d1, score_d0}, {4'd0, e.score});
        checkOutput("hi", {4'd0, hi_d2, hi_d1, hi_d0}, {4'd0, e.hi});
        checkOutput("lives", {12'd0, lives}, {12'd0, e.lives});
        checkOutput("playing", {15'd0, playing}, {15'd0, e.playing});
        checkOutput("gameOver", {15'd0, game_over}, {15'd0, e.over});
    endtask

    task automatic modelReset();
        mState = 0;
        mScore = 0;
        mHi    = 0;
        mLives = LIVES_INIT;
    endtask

    task automatic modelStep(input bit s, input bit h, input bit m, input bit b);
        if (mState != 1) begin
            if (s) begin
                mState = 1;
                mScore = 0;
                mLives = LIVES_INIT;
            end
        end else begin
            if (b) begin
                mLives = 0;
            end else begin
                if (h && mScore < 999) mScore++;
                if (m && mLives > 0) mLives--;
            end
            if (mLives == 0) begin
                mState = 2;
                if (mScore > mHi) mHi = mScore;
            end
        end
    endtask

    // One clock cycle of stimulus, with its prediction checked after the edge
    task automatic applyStimulus(input bit s, input bit h, input bit m, input bit b);
        @(negedge clock);
        start = s;
        hit   = h;
        miss  = m;
        bomb  = b;
        modelStep(s, h, m, b);
        pushExpected();
        @(posedge clock);
        #1;
        start = 1'b0;
        hit   = 1'b0;
        miss  = 1'b0;
        bomb  = 1'b0;
        popAndCompare();
    endtask

    task automatic hits(input int n);
        for (int i = 0; i < n; i++) applyStimulus(0, 1, 0, 0);
    endtask

    // Reset asserted between edges must clear everything without a clock
    task automatic asyncReset();
        @(posedge clock);
        #3;
        resetn = 1'b0;
        #1;
        modelReset();
        pushExpected();
        popAndCompare();
        @(negedge clock);
        resetn = 1'b1;
    endtask

    task automatic playGame(input int nHits);
        applyStimulus(1, 0, 0, 0);
        hits(nHits);
        applyStimulus(0, 0, 0, 1);
    endtask

    initial begin
        #12;
        modelReset();
        pushExpected();
        popAndCompare();
        @(negedge clock);
        resetn = 1'b1;

        // Idle ignores game events
        applyStimulus(0, 1, 1, 1);
        applyStimulus(1, 0, 0, 0);

        // Carries through every digit and saturation at 999
        hits(1001);

        // Lives run out on the third miss; later events ignored
        applyStimulus(0, 0, 1, 0);
        applyStimulus(0, 0, 1, 0);
        applyStimulus(0, 0, 1, 0);
        applyStimulus(0, 1, 0, 0);
        applyStimulus(0, 0, 1, 0);

        // Simultaneous hit+miss on last life counts the hit
        asyncReset();
        applyStimulus(1, 0, 0, 0);
        hits(41);
        applyStimulus(0, 0, 1, 0);
        applyStimulus(0, 0, 1, 0);
        applyStimulus(0, 1, 1, 0);

        // Hit+bomb discards the hit; miss+bomb behaves as bomb
        applyStimulus(1, 0, 0, 0);
        hits(10);
        applyStimulus(0, 1, 0, 1);
        applyStimulus(1, 0, 0, 0);
        applyStimulus(0, 0, 1, 1);

        // High score retention across games
        asyncReset();
        playGame(57);
        playGame(23);
        playGame(57);
        applyStimulus(1, 0, 0, 0);
        hits(30);
        applyStimulus(1, 0, 0, 0);
        hits(28);
        applyStimulus(0, 0, 0, 1);

        // Reset mid-game clears the high score too
        applyStimulus(1, 0, 0, 0);
        hits(5);
        asyncReset();
        applyStimulus(0, 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule

// File: doc/score_keeper.md
Name: score_keeper

Overview:
- Game-side score/lives bookkeeping for Fruit Ninja.
- Counts slices as a 3-digit BCD score, tracks remaining lives and a session high score, and sequences IDLE/PLAY/OVER.
- Sits directly upstream of the seven-segment decoders. Each 4-bit digit output drives one decoder instance with a value 0-9.
- Lives and high score drive further decoder instances.

Parameters:
- LIVES_INIT, 3, lives loaded at reset and at game start. Legal range 1-9.

Ports:
- clock  input  1  system clock; all state changes on its rising edge
- resetn  input  1  asynchronous, active-low reset
- start  input  1  pulse: begin a new game
- hit  input  1  pulse: one fruit sliced
- miss  input  1  pulse: one fruit dropped
- bomb  input  1  pulse: bomb sliced
- score_d0  output  4  score ones digit, BCD
- score_d1  output  4  score tens digit, BCD
- score_d2  output  4  score hundreds digit, BCD
- hi_d0  output  4  high score ones digit, BCD
- hi_d1  output  4  high score tens digit, BCD
- hi_d2  output  4  high score hundreds digit, BCD
- lives  output  4  remaining lives, 0..LIVES_INIT
- playing  output  1  high in PLAY
- game_over  output  1  high in OVER

Behaviour:
- Interface clocking: one clock, `clock`. `resetn` is asynchronous and active-low.
- Registered outputs: all outputs are registered. Effect of any input is visible the cycle after the sampling edge (latency 1).
- Input sampling: each of start/hit/miss/bomb counts once per clock cycle in which it is high. Edge detection is the upstream block's job.
- Reset (resetn low, asynchronous, any state, any time):
  - state=IDLE
  - score digits=0
  - hi digits=0
  - lives=LIVES_INIT
  - playing=0, game_over=0
- States:
  - IDLE: hit/miss/bomb ignored. start -> PLAY, score cleared to 000, lives=LIVES_INIT.
  - PLAY, hit: score +1 in BCD.
    - Ones digit 9 -> 0 with carry into tens; tens 9 -> 0 with carry into hundreds.
    - Score saturates at 999: hit at 999 leaves 999, no wrap.
    - Digits never leave 0-9.
  - PLAY, miss: lives -1.
  - PLAY, bomb: lives forced to 0.
  - PLAY, next-lives = 0 (from miss or bomb): transition to OVER on the same edge. lives shows 0.
  - PLAY, start: ignored, no restart mid-game.
  - OVER: hit/miss/bomb ignored; score frozen. start -> PLAY with score=000, lives=LIVES_INIT. High score is retained.
- High score:
  - Updated on the PLAY->OVER edge only.
  - New score replaces the high score if strictly greater. Compare hundreds, then tens, then ones.
  - Equal score: no change.
- Simultaneous events in PLAY:
  - hit+miss: both applied; score +1 and lives -1. If lives reaches 0, the final score includes the hit and the high score compare uses it.
  - hit+bomb: bomb wins, hit discarded.
  - miss+bomb: treated as bomb.
- lives is never decremented below 0.
- Reset mid-game clears the high score as well.

Test Plan:
- Reset then start: score 000, lives 3, playing=1, game_over=0.
- Carry: 9 hits -> score 009; 10th hit -> 010; continue to 99 hits -> 099; 100th -> 100, all digits BCD throughout.
- Saturation: 999 hits then 2 more -> score stays 999, lives 3.
- Lives to over:
  - 3 miss pulses -> lives 2,1,0, with game_over=1 on the cycle lives shows 0.
  - After game over, hit/miss ignored: score unchanged, lives 0.
- Simultaneous:
  - hit+miss at lives 1, score 041 -> score 042, lives 0, OVER, hi 042.
  - hit+bomb at score 010 -> score 010, lives 0.
- High score:
  - Game 1 ends at 057 -> hi 057.
  - Restart, game 2 ends at 023 -> hi 057.
  - Restart, game 3 ends at 057 -> hi 057.
  - Game 4 ends at 058 -> hi 058.
  - Assert resetn low mid-game -> all outputs return to their reset values immediately (asynchronous), including hi=000.
